ddr2_read_fetcher: RTL and testbench

//  Read-side DRAM engine for the RAMTester datapath, the counterpart of the pipe-in/DDR2 write path.

---
 rtl/ddr2_read_fetcher.sv | 133 +++++++++++++
 tb/tb_ddr2_read_fetcher.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_read_fetcher.sv
// Read-side DRAM engine: issues sequential fixed-length read bursts on MCB port p1
// and streams the returned words into the pipe-out FIFO, one burst in flight at a time.
module ddr2_read_fetcher #(
    parameter int unsigned           BURST_LEN    = 32,
    parameter int unsigned           ADDR_WIDTH   = 30,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT   = 30'h0800_0000,
    parameter int unsigned           OB_DEPTH     = 1024,
    parameter int unsigned           OB_CNT_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    calib_done,
    input  logic                    rd_mode,
    input  logic                    addr_reset,
    output logic                    p1_cmd_en,
    output logic [2:0]              p1_cmd_instr,
    output logic [5:0]              p1_cmd_bl,
    output logic [ADDR_WIDTH-1:0]   p1_cmd_byte_addr,
    input  logic                    p1_cmd_full,
    output logic                    p1_rd_en,
    input  logic [31:0]             p1_rd_data,
    input  logic                    p1_rd_empty,
    output logic                    ob_wr_en,
    output logic [31:0]             ob_din,
    input  logic [OB_CNT_WIDTH-1:0] ob_count,
    output logic                    busy
);

    localparam logic [ADDR_WIDTH:0]     ADDR_STEP = (ADDR_WIDTH + 1)'(4 * BURST_LEN);
    localparam logic [OB_CNT_WIDTH-1:0] OB_ADMIT  = OB_CNT_WIDTH'(OB_DEPTH - BURST_LEN);
    localparam logic [6:0]              REM_INIT  = 7'(BURST_LEN);
    localparam logic [5:0]              BL_CODE   = 6'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [6:0]              remaining_q, remaining_d;
    logic                    rst_pend_q, rst_pend_d;
    logic                    cmd_en_q, cmd_en_d;
    logic [2:0]              cmd_instr_q, cmd_instr_d;
    logic [5:0]              cmd_bl_q, cmd_bl_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic                    ob_wr_en_q;
    logic [31:0]             ob_din_q, ob_din_d;
    logic                    rd_en;
    logic [ADDR_WIDTH:0]     addr_inc;
    logic [ADDR_WIDTH-1:0]   addr_next;

    assign rd_en = (state_q == S_DATA) && !p1_rd_empty && (remaining_q != '0);

    // One extra bit so the limit compare cannot be fooled by carry-out.
    assign addr_inc  = {1'b0, rd_addr_q} + ADDR_STEP;
    assign addr_next = (addr_inc >= {1'b0, ADDR_LIMIT}) ? '0 : addr_inc[ADDR_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        rst_pend_d  = rst_pend_q;
        cmd_en_d    = 1'b0;
        cmd_instr_d = cmd_instr_q;
        cmd_bl_d    = cmd_bl_q;
        cmd_addr_d  = cmd_addr_q;
        ob_din_d    = rd_en ? p1_rd_data : ob_din_q;
        case (state_q)
            S_IDLE: begin
                if (addr_reset) begin
                    rd_addr_d = '0;
                end else if (calib_done && rd_mode && !p1_cmd_full && (ob_count <= OB_ADMIT)) begin
                    state_d     = S_CMD;
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = 3'b001;
                    cmd_bl_d    = BL_CODE;
                    cmd_addr_d  = rd_addr_q;
                end
            end
            S_CMD: begin
                remaining_d = REM_INIT;
                state_d     = S_DATA;
                if (addr_reset) rst_pend_d = 1'b1;
            end
            S_DATA: begin
                if (addr_reset) rst_pend_d = 1'b1;
                if (rd_en) begin
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        rd_addr_d  = (rst_pend_q || addr_reset) ? '0 : addr_next;
                        rst_pend_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            rst_pend_q  <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_instr_q <= '0;
            cmd_bl_q    <= '0;
            cmd_addr_q  <= '0;
            ob_wr_en_q  <= 1'b0;
            ob_din_q    <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            rst_pend_q  <= rst_pend_d;
            cmd_en_q    <= cmd_en_d;
            cmd_instr_q <= cmd_instr_d;
            cmd_bl_q    <= cmd_bl_d;
            cmd_addr_q  <= cmd_addr_d;
            ob_wr_en_q  <= rd_en;
            ob_din_q    <= ob_din_d;
        end
    end

    assign p1_cmd_en        = cmd_en_q;
    assign p1_cmd_instr     = cmd_instr_q;
    assign p1_cmd_bl        = cmd_bl_q;
    assign p1_cmd_byte_addr = cmd_addr_q;
    assign p1_rd_en         = rd_en;
    assign ob_wr_en         = ob_wr_en_q;
    assign ob_din           = ob_din_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr2_read_fetcher.sv
// Directed bench for ddr2_read_fetcher: MCB read-port model plus a second instance
// with a small address limit to exercise pointer wrap.
module tb_ddr2_read_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        calib_done = 1'b0;
    logic        rd_mode = 1'b0;
    logic        addr_reset = 1'b0;
    logic        p1_cmd_full = 1'b0;
    logic [10:0] ob_count = '0;
    logic        p1_rd_empty = 1'b1;
    logic [31:0] p1_rd_data = '0;
    logic        p1_cmd_en, p1_rd_en, ob_wr_en, busy;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic [31:0] ob_din;

    logic        rst2_n = 1'b0;
    logic        rd_mode2 = 1'b0;
    logic        cmd_en2, rd_en2, wr2, busy2;
    logic [2:0]  instr2;
    logic [5:0]  bl2;
    logic [29:0] addr2;
    logic [31:0] din2;

    logic        rnd = 1'b0, gap_en = 1'b0, flush = 1'b0;
    logic        s_pop, s_cmd;
    int unsigned gen_val = 0;
    int unsigned wr2_cnt = 0, pop2_cnt = 0;
    logic [31:0] last_din2 = '0;
    logic [31:0] mq[$];
    logic [31:0] rx[$];
    logic [29:0] ca[$];
    logic [2:0]  ci[$];
    logic [5:0]  cb[$];
    logic [29:0] ca2[$];
    logic [8:0]  cib2[$];
    int unsigned total = 0, bad = 0;

    always #5 clk = ~clk;

    ddr2_read_fetcher dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .rd_mode(rd_mode),
        .addr_reset(addr_reset), .p1_cmd_en(p1_cmd_en), .p1_cmd_instr(p1_cmd_instr),
        .p1_cmd_bl(p1_cmd_bl), .p1_cmd_byte_addr(p1_cmd_byte_addr), .p1_cmd_full(p1_cmd_full),
        .p1_rd_en(p1_rd_en), .p1_rd_data(p1_rd_data), .p1_rd_empty(p1_rd_empty),
        .ob_wr_en(ob_wr_en), .ob_din(ob_din), .ob_count(ob_count), .busy(busy)
    );

    ddr2_read_fetcher #(.ADDR_LIMIT(30'h100)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .calib_done(1'b1), .rd_mode(rd_mode2),
        .addr_reset(1'b0), .p1_cmd_en(cmd_en2), .p1_cmd_instr(instr2),
        .p1_cmd_bl(bl2), .p1_cmd_byte_addr(addr2), .p1_cmd_full(1'b0),
        .p1_rd_en(rd_en2), .p1_rd_data(32'hC0DE_0001), .p1_rd_empty(1'b0),
        .ob_wr_en(wr2), .ob_din(din2), .ob_count(11'd0), .busy(busy2)
    );

    // MCB read-port model: each command queues 32 incrementing words; monitors sample at negedge.
    always begin
        @(negedge clk);
        s_pop = p1_rd_en;
        s_cmd = p1_cmd_en;
        if (ob_wr_en) rx.push_back(ob_din);
        if (p1_cmd_en) begin
            ca.push_back(p1_cmd_byte_addr);
            ci.push_back(p1_cmd_instr);
            cb.push_back(p1_cmd_bl);
        end
        if (cmd_en2) begin
            ca2.push_back(addr2);
            cib2.push_back({instr2, bl2});
        end
        if (wr2) begin
            wr2_cnt++;
            last_din2 = din2;
        end
        if (rd_en2) pop2_cnt++;
        @(posedge clk);
        #1;
        if (s_pop && mq.size() != 0) void'(mq.pop_front());
        if (s_cmd) for (int i = 0; i < 32; i++) begin
            mq.push_back(gen_val);
            gen_val++;
        end
        if (flush) mq.delete();
        if (rnd) begin
            p1_rd_empty = 1'($urandom);
            p1_rd_data  = $urandom;
        end else begin
            p1_rd_empty = (mq.size() == 0) || (gap_en && ($urandom_range(0, 2) == 0));
            p1_rd_data  = (mq.size() != 0) ? mq[0] : 32'h0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rx.delete();
        ca.delete();
        ci.delete();
        cb.delete();
        gen_val = 0;
    endtask

    task automatic do_reset();
        rd_mode = 1'b0;
        addr_reset = 1'b0;
        p1_cmd_full = 1'b0;
        ob_count = '0;
        calib_done = 1'b1;
        rst_n = 1'b0;
        flush = 1'b1;
        repeat (3) tick();
        clear_logs();
        flush = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic wait_cmds(input int unsigned n, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (ca.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ca.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_rx(input int unsigned n, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (rx.size() >= n) break;
            tick();
        end
        if (rx.size() >= n) ok = 1'b1;
    endtask

    task automatic settle();
        rd_mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            tick();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL settle_idle busy=%b required=0", busy);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        bit ok;
        rnd = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            calib_done = 1'($urandom);
            rd_mode = 1'($urandom);
            addr_reset = 1'($urandom);
            p1_cmd_full = 1'($urandom);
            ob_count = 11'($urandom);
            tick();
            total++;
            if ({p1_cmd_en, p1_rd_en, ob_wr_en, busy} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b required=0000", i,
                         {p1_cmd_en, p1_rd_en, ob_wr_en, busy});
            end
        end
        rnd = 1'b0;
        flush = 1'b1;
        calib_done = 1'b1;
        rd_mode = 1'b1;
        addr_reset = 1'b0;
        p1_cmd_full = 1'b0;
        ob_count = '0;
        tick();
        flush = 1'b0;
        clear_logs();
        rst_n = 1'b1;
        wait_cmds(1, 10, ok);
        total++;
        if (!ok || ca[0] !== 30'h0) begin
            bad++;
            $display("FAIL reset_first_addr seen=%0d addr=%h required=0", ca.size(), ca[0]);
        end
        settle();
    endtask

    task automatic test_single_burst();
        bit ok;
        bit order_ok;
        do_reset();
        gap_en = 1'b1;
        rd_mode = 1'b1;
        wait_cmds(1, 10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_cmd_timeout seen=%0d required=1", ca.size());
        end
        if (ok) begin
            total++;
            if (ci[0] !== 3'b001) begin
                bad++;
                $display("FAIL single_instr got=%b required=001", ci[0]);
            end
            total++;
            if (cb[0] !== 6'd31) begin
                bad++;
                $display("FAIL single_bl got=%0d required=31", cb[0]);
            end
            total++;
            if (ca[0] !== 30'h0) begin
                bad++;
                $display("FAIL single_addr got=%h required=0", ca[0]);
            end
        end
        wait_cmds(2, 200, ok);
        total++;
        if (!ok || ca[1] !== 30'h80) begin
            bad++;
            $display("FAIL single_next_addr seen=%0d addr=%h required=80", ca.size(), ca[1]);
        end
        total++;
        if (rx.size() != 32) begin
            bad++;
            $display("FAIL single_word_count got=%0d required=32", rx.size());
        end
        order_ok = 1'b1;
        for (int i = 0; i < 32 && i < rx.size(); i++) begin
            if (order_ok && rx[i] !== 32'(i)) begin
                order_ok = 1'b0;
                $display("FAIL single_word_order idx=%0d got=%0d required=%0d", i, rx[i], i);
            end
        end
        total++;
        if (!order_ok) bad++;
        settle();
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        gap_en = 1'b0;
        ob_count = 11'd993;
        rd_mode = 1'b1;
        repeat (100) tick();
        total++;
        if (ca.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_full_ob cmds=%0d busy=%b required=0/0", ca.size(), busy);
        end
        ob_count = 11'd992;
        wait_cmds(1, 2, ok);
        total++;
        if (!ok || ca[0] !== 30'h0) begin
            bad++;
            $display("FAIL bp_admit seen=%0d addr=%h required=1 cmd at 0", ca.size(), ca[0]);
        end
        p1_cmd_full = 1'b1;
        repeat (100) tick();
        total++;
        if (ca.size() != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_cmd_full cmds=%0d busy=%b required=1/0", ca.size(), busy);
        end
        total++;
        if (rx.size() != 32) begin
            bad++;
            $display("FAIL bp_word_count got=%0d required=32", rx.size());
        end
        p1_cmd_full = 1'b0;
        wait_cmds(2, 3, ok);
        total++;
        if (!ok || ca[1] !== 30'h80) begin
            bad++;
            $display("FAIL bp_release seen=%0d addr=%h required=80", ca.size(), ca[1]);
        end
        settle();
    endtask

    task automatic test_wrap();
        logic [29:0] exp_addr [4];
        exp_addr[0] = 30'h00;
        exp_addr[1] = 30'h80;
        exp_addr[2] = 30'h00;
        exp_addr[3] = 30'h80;
        rst2_n = 1'b1;
        rd_mode2 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ca2.size() >= 4) break;
            tick();
        end
        total++;
        if (ca2.size() < 4) begin
            bad++;
            $display("FAIL wrap_timeout seen=%0d required=4", ca2.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (ca2[i] !== exp_addr[i] || cib2[i] !== {3'b001, 6'd31}) begin
                    bad++;
                    $display("FAIL wrap_cmd idx=%0d got=%h/%h required=%h/%h", i, ca2[i], cib2[i],
                             exp_addr[i], {3'b001, 6'd31});
                end
            end
            total++;
            if (wr2_cnt != 96 || pop2_cnt != 96 || last_din2 !== 32'hC0DE_0001) begin
                bad++;
                $display("FAIL wrap_words wr=%0d pop=%0d din=%h required=96/96/c0de0001",
                         wr2_cnt, pop2_cnt, last_din2);
            end
        end
        rd_mode2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy2) break;
            tick();
        end
        total++;
        if (busy2 !== 1'b0) begin
            bad++;
            $display("FAIL wrap_idle busy=%b required=0", busy2);
        end
    endtask

    task automatic test_addr_reset();
        bit ok;
        bit order_ok;
        do_reset();
        gap_en = 1'b1;
        rd_mode = 1'b1;
        wait_cmds(4, 400, ok);
        total++;
        if (!ok || ca[3] !== 30'h180) begin
            bad++;
            $display("FAIL ar_fourth_addr seen=%0d addr=%h required=180", ca.size(), ca[3]);
        end
        wait_rx(106, 120, ok);
        addr_reset = 1'b1;
        tick();
        addr_reset = 1'b0;
        wait_cmds(5, 150, ok);
        total++;
        if (!ok || ca[4] !== 30'h0) begin
            bad++;
            $display("FAIL ar_next_addr seen=%0d addr=%h required=0", ca.size(), ca[4]);
        end
        total++;
        if (rx.size() != 128) begin
            bad++;
            $display("FAIL ar_word_count got=%0d required=128", rx.size());
        end
        order_ok = 1'b1;
        for (int i = 96; i < 128 && i < rx.size(); i++) begin
            if (order_ok && rx[i] !== 32'(i)) begin
                order_ok = 1'b0;
                $display("FAIL ar_word_order idx=%0d got=%0d required=%0d", i, rx[i], i);
            end
        end
        total++;
        if (!order_ok) bad++;
        settle();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        gap_en = 1'b0;
        rd_mode = 1'b1;
        wait_cmds(1, 10, ok);
        wait_rx(5, 20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_reset_setup words=%0d required>=5", rx.size());
        end
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        total++;
        if ({p1_rd_en, p1_cmd_en, busy} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_rd_en got=%b required=000", {p1_rd_en, p1_cmd_en, busy});
        end
        tick();
        total++;
        if (ob_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_wr_en got=%b required=0", ob_wr_en);
        end
        clear_logs();
        flush = 1'b0;
        rst_n = 1'b1;
        wait_cmds(1, 10, ok);
        total++;
        if (!ok || ca[0] !== 30'h0) begin
            bad++;
            $display("FAIL mid_reset_next_addr seen=%0d addr=%h required=0", ca.size(), ca[0]);
        end
        settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_wrap();
        test_addr_reset();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
